// File: rtl/dpi_pkg.sv
// Shared widths and FSM encoding for the DPI stream sequencer and its stream table.
package dpi_pkg;

    localparam int unsigned NUM_SID = 64;
    localparam int unsigned SID_W   = 6;
    localparam int unsigned KEY_W   = 16;
    localparam int unsigned EOP_GAP = 1;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned GAP_W   = (EOP_GAP > 1) ? $clog2(EOP_GAP) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY1,
        ST_LOOKUP,
        ST_LOAD,
        ST_GAP,
        ST_STREAM,
        ST_EOP_WAIT,
        ST_EOP
    } seq_state_t;

endpackage

// File: rtl/dpi_stream_sequencer_if.sv
// Byte-serial packet ingress bus with valid/ready handshake and sop/eop framing.
interface dpi_stream_sequencer_if;

    logic [7:0] pkt_data;
    logic       pkt_vld;
    logic       pkt_sop;
    logic       pkt_eop;
    logic       pkt_rdy;

    modport master (output pkt_data, pkt_vld, pkt_sop, pkt_eop, input pkt_rdy);
    modport slave  (input pkt_data, pkt_vld, pkt_sop, pkt_eop, output pkt_rdy);

endinterface

// File: rtl/dpi_stream_table.sv
// Fully associative flow-key to stream-ID table with single-cycle lookup/allocate.
module dpi_stream_table
    import dpi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key,
    input  logic             alloc,
    output logic             hit_c,
    output logic [SID_W-1:0] sid_c
);

    logic [KEY_W-1:0]   keys [NUM_SID];
    logic [NUM_SID-1:0] valid;
    logic [SID_W-1:0]   rep_ptr;
    logic               free_c;
    logic [SID_W-1:0]   hit_idx_c;
    logic [SID_W-1:0]   free_idx_c;

    // Descending scan so the lowest matching / lowest free index wins.
    always_comb begin
        hit_c      = 1'b0;
        free_c     = 1'b0;
        hit_idx_c  = '0;
        free_idx_c = '0;
        for (int i = int'(NUM_SID) - 1; i >= 0; i--) begin
            if (valid[i] && (keys[i] == key)) begin
                hit_c     = 1'b1;
                hit_idx_c = SID_W'(i);
            end
            if (!valid[i]) begin
                free_c     = 1'b1;
                free_idx_c = SID_W'(i);
            end
        end
        sid_c = hit_c ? hit_idx_c : (free_c ? free_idx_c : rep_ptr);
    end

    // rep_ptr wraps at NUM_SID naturally since NUM_SID == 2**SID_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= '0;
            rep_ptr <= '0;
        end else if (alloc && !hit_c) begin
            valid[sid_c] <= 1'b1;
            if (!free_c) begin
                rep_ptr <= rep_ptr + SID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc && !hit_c) begin
            keys[sid_c] <= key;
        end
    end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Packet-to-matcher sequencer: extracts the flow key, maps it to a stream ID and
// drives load_state / payload chars / eop to the per-regex matchers.
module dpi_stream_sequencer
    import dpi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    dpi_stream_sequencer_if.slave pkt,
    input  logic                  cfg_we,
    input  logic [SID_W-1:0]      cfg_sid,
    input  logic                  cfg_en,
    output logic [BYTE_W-1:0]     char_in,
    output logic                  char_in_vld,
    output logic                  load_state,
    output logic [SID_W-1:0]      stream_id,
    output logic                  new_stream_id,
    output logic                  enable,
    output logic                  eop,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      drop_cnt
);

    seq_state_t         state;
    logic               rdy;
    logic               accept_c;
    logic [KEY_W-1:0]   key;
    logic [SID_W-1:0]   sid_q;
    logic               new_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic [NUM_SID-1:0] mask;
    logic               tbl_hit_c;
    logic [SID_W-1:0]   tbl_sid_c;

    assign pkt.pkt_rdy = rdy;
    assign accept_c    = pkt.pkt_vld && rdy;

    dpi_stream_table u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key),
        .alloc (state == ST_LOOKUP),
        .hit_c (tbl_hit_c),
        .sid_c (tbl_sid_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else if (cfg_we) begin
            mask[cfg_sid] <= cfg_en;
        end
    end

    // Outputs trail the state by one cycle; rdy is registered alongside the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rdy           <= 1'b0;
            key           <= '0;
            sid_q         <= '0;
            new_q         <= 1'b0;
            gap_cnt       <= '0;
            char_in       <= '0;
            char_in_vld   <= 1'b0;
            load_state    <= 1'b0;
            new_stream_id <= 1'b0;
            stream_id     <= '0;
            enable        <= 1'b0;
            eop           <= 1'b0;
            pkt_cnt       <= '0;
            drop_cnt      <= '0;
        end else begin
            char_in_vld   <= 1'b0;
            load_state    <= 1'b0;
            new_stream_id <= 1'b0;
            eop           <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rdy <= 1'b1;
                    if (accept_c && pkt.pkt_sop) begin
                        key[KEY_W-1 -: 8] <= pkt.pkt_data;
                        if (pkt.pkt_eop) begin
                            drop_cnt <= drop_cnt + CNT_W'(1);
                        end else begin
                            state <= ST_KEY1;
                        end
                    end
                end
                ST_KEY1: begin
                    if (accept_c) begin
                        key[7:0] <= pkt.pkt_data;
                        if (pkt.pkt_eop) begin
                            drop_cnt <= drop_cnt + CNT_W'(1);
                            state    <= ST_IDLE;
                        end else begin
                            rdy   <= 1'b0;
                            state <= ST_LOOKUP;
                        end
                    end
                end
                ST_LOOKUP: begin
                    sid_q <= tbl_sid_c;
                    new_q <= !tbl_hit_c;
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    load_state    <= 1'b1;
                    new_stream_id <= new_q;
                    stream_id     <= sid_q;
                    // Forward a same-cycle mask write so the latched enable is current.
                    enable        <= (cfg_we && (cfg_sid == sid_q)) ? cfg_en : mask[sid_q];
                    state         <= ST_GAP;
                end
                ST_GAP: begin
                    rdy   <= 1'b1;
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (accept_c) begin
                        char_in     <= pkt.pkt_data;
                        char_in_vld <= 1'b1;
                        if (pkt.pkt_eop) begin
                            rdy     <= 1'b0;
                            gap_cnt <= '0;
                            state   <= ST_EOP_WAIT;
                        end
                    end
                end
                ST_EOP_WAIT: begin
                    if (gap_cnt == GAP_W'(EOP_GAP - 1)) begin
                        state <= ST_EOP;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_EOP: begin
                    eop     <= 1'b1;
                    pkt_cnt <= pkt_cnt + CNT_W'(1);
                    rdy     <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    rdy   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Self-checking bench for dpi_stream_sequencer: directed vector table, hand-written
// corner sequences and randomized packets against a key->sid map reference model.
module tb_dpi_stream_sequencer;
    import dpi_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dpi_stream_sequencer_if pkt_if ();

    logic               cfg_we;
    logic [SID_W-1:0]   cfg_sid;
    logic               cfg_en;
    logic [7:0]         char_in;
    logic               char_in_vld;
    logic               load_state;
    logic [SID_W-1:0]   stream_id;
    logic               new_stream_id;
    logic               enable;
    logic               eop;
    logic [15:0]        pkt_cnt;
    logic [15:0]        drop_cnt;

    dpi_stream_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pkt           (pkt_if),
        .cfg_we        (cfg_we),
        .cfg_sid       (cfg_sid),
        .cfg_en        (cfg_en),
        .char_in       (char_in),
        .char_in_vld   (char_in_vld),
        .load_state    (load_state),
        .stream_id     (stream_id),
        .new_stream_id (new_stream_id),
        .enable        (enable),
        .eop           (eop),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    typedef struct { int cyc; logic [SID_W-1:0] sid; logic nw; logic en; } ev_t;
    typedef struct { int cyc; logic [7:0] d; } ch_t;
    ev_t ld_q[$];
    ev_t eop_q[$];
    ch_t ch_q[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (load_state === 1'b1) ld_q.push_back('{cyc, stream_id, new_stream_id, enable});
            if (char_in_vld === 1'b1) ch_q.push_back('{cyc, char_in});
            if (eop === 1'b1) eop_q.push_back('{cyc, stream_id, new_stream_id, enable});
        end
    end

    // Reference model: flow map plus allocation order (slots fill 0..63, then round-robin eviction).
    int m_map[int];
    int m_owner[NUM_SID];
    int m_used, m_ptr, m_pkts, m_drops;
    bit m_mask[NUM_SID];

    function automatic void model_reset();
        m_map.delete();
        m_used = 0; m_ptr = 0; m_pkts = 0; m_drops = 0;
        for (int i = 0; i < int'(NUM_SID); i++) m_mask[i] = 1'b0;
    endfunction

    function automatic void model_stream(input int k, output int sid, output bit nw);
        if (m_map.exists(k)) begin
            sid = m_map[k];
            nw  = 1'b0;
        end else begin
            nw = 1'b1;
            if (m_used < int'(NUM_SID)) begin
                sid = m_used;
                m_used++;
            end else begin
                sid = m_ptr;
                m_map.delete(m_owner[sid]);
                m_ptr = (m_ptr + 1) % int'(NUM_SID);
            end
            m_map[k]     = sid;
            m_owner[sid] = k;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outs"}, 32'({char_in, char_in_vld, load_state, new_stream_id, eop,
                                   stream_id, enable, pkt_if.pkt_rdy}), 32'd0);
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    // Called on a falling edge; drives one byte and returns on the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] d, input logic s, input logic e, input logic cw);
        int n = 0;
        while (pkt_if.pkt_rdy !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                total++; bad++;
                $display("FAIL rdy_timeout: pkt_rdy low for %0d cycles, required high", n);
                return;
            end
        end
        pkt_if.pkt_data = d;
        pkt_if.pkt_sop  = s;
        pkt_if.pkt_eop  = e;
        pkt_if.pkt_vld  = 1'b1;
        cfg_we          = cw;
        @(negedge clk);
        pkt_if.pkt_vld = 1'b0;
        pkt_if.pkt_sop = 1'b0;
        pkt_if.pkt_eop = 1'b0;
        cfg_we         = 1'b0;
    endtask

    task automatic do_cfg(input int s, input bit v);
        cfg_sid = SID_W'(s);
        cfg_en  = v;
        cfg_we  = 1'b1;
        @(negedge clk);
        cfg_we    = 1'b0;
        m_mask[s] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        ld_q.delete(); ch_q.delete(); eop_q.delete();
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] pay[8];
    bit obs_load, obs_new, obs_en;
    int obs_sid;

    task automatic run_pkt(input logic [15:0] key, input int hdr, input int plen, input int gap,
                           input bit stray, input bit mid_cfg, input int mc_sid, input bit mc_en);
        int sid = 0;
        bit nw = 1'b0, en = 1'b0, drop;
        int n, exp_cyc;
        ev_t l, e;
        ld_q.delete(); ch_q.delete(); eop_q.delete();
        obs_load = 1'b0; obs_sid = -1; obs_new = 1'b0; obs_en = 1'b0;
        drop = (hdr < 2) || (plen == 0);
        if (drop) m_drops++;
        else begin
            model_stream(int'(key), sid, nw);
            en = m_mask[sid];
            m_pkts++;
        end
        if (stray) send_byte(8'h5A, 1'b0, 1'b0, 1'b0);
        send_byte(key[15:8], 1'b1, hdr == 1, 1'b0);
        if (hdr == 2) send_byte(key[7:0], 1'b0, plen == 0, 1'b0);
        if (mid_cfg) begin
            cfg_sid = SID_W'(mc_sid);
            cfg_en  = mc_en;
        end
        for (int i = 0; i < plen; i++) begin
            if (i > 0) repeat (gap) @(negedge clk);
            send_byte(pay[i], 1'b0, i == plen - 1, mid_cfg && (i == 0));
        end
        if (mid_cfg && plen > 0) m_mask[mc_sid] = mc_en;

        if (drop) begin
            check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
            check("rdy_after_drop", 32'(pkt_if.pkt_rdy), 32'd1);
            repeat (3) @(negedge clk);
            check("no_load_on_drop", 32'(ld_q.size()), 32'd0);
            check("pkt_cnt_on_drop", 32'(pkt_cnt), 32'(m_pkts));
            return;
        end

        n = 0;
        while (eop_q.size() == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (eop_q.size() == 0) begin
            total++; bad++;
            $display("FAIL eop_timeout: no eop within %0d cycles for key 0x%0h", n, key);
            return;
        end
        check("load_count", 32'(ld_q.size()), 32'd1);
        if (ld_q.size() == 0) return;
        l = ld_q[0];
        e = eop_q[0];
        obs_load = 1'b1; obs_sid = int'(l.sid); obs_new = l.nw; obs_en = l.en;
        check("sid", 32'(l.sid), 32'(sid));
        check("new_stream_id", 32'(l.nw), 32'(nw));
        check("enable", 32'(l.en), 32'(en));
        check("char_count", 32'(ch_q.size()), 32'(plen));
        for (int i = 0; i < plen && i < ch_q.size(); i++) begin
            check("char_data", 32'(ch_q[i].d), 32'(pay[i]));
            check("char_cycle", 32'(ch_q[i].cyc), 32'(l.cyc + 2 + i * (gap + 1)));
        end
        exp_cyc = l.cyc + 2 + (plen - 1) * (gap + 1) + int'(EOP_GAP) + 1;
        check("eop_cycle", 32'(e.cyc), 32'(exp_cyc));
        check("eop_sid_stable", 32'(e.sid), 32'(sid));
        check("eop_enable_stable", 32'(e.en), 32'(en));
        check("pkt_cnt", 32'(pkt_cnt), 32'(m_pkts));
    endtask

    typedef struct {
        logic [15:0] key; int hdr; int plen; int gap; bit stray; logic [7:0] base;
        bit pre_cfg; int cfg_s; bit cfg_v;
        bit exp_load; int exp_sid; bit exp_new; bit exp_en; int exp_drops;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hABCD, 2, 3, 0, 1'b0, 8'h61, 1'b0, 0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0};
        vecs[1] = '{16'hABCD, 2, 3, 3, 1'b0, 8'h61, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 0};
        vecs[2] = '{16'h1234, 2, 0, 0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1};
        vecs[3] = '{16'h7777, 1, 0, 0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2};
        vecs[4] = '{16'h5555, 2, 1, 0, 1'b1, 8'h10, 1'b1, 1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 2};
        vecs[5] = '{16'hABCD, 2, 2, 1, 1'b0, 8'h30, 1'b1, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 2};

        rst_n = 1'b0;
        pkt_if.pkt_data = '0; pkt_if.pkt_vld = 1'b0; pkt_if.pkt_sop = 1'b0; pkt_if.pkt_eop = 1'b0;
        cfg_we = 1'b0; cfg_sid = '0; cfg_en = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 8; i++) pay[i] = vecs[v].base + 8'(i);
            if (vecs[v].pre_cfg) do_cfg(vecs[v].cfg_s, vecs[v].cfg_v);
            run_pkt(vecs[v].key, vecs[v].hdr, vecs[v].plen, vecs[v].gap, vecs[v].stray, 1'b0, 0, 1'b0);
            check("vec_load", 32'(obs_load), 32'(vecs[v].exp_load));
            if (vecs[v].exp_load) begin
                check("vec_sid", 32'(obs_sid), 32'(vecs[v].exp_sid));
                check("vec_new", 32'(obs_new), 32'(vecs[v].exp_new));
                check("vec_en", 32'(obs_en), 32'(vecs[v].exp_en));
            end
            check("vec_drops", 32'(drop_cnt), 32'(vecs[v].exp_drops));
        end

        // Reset in the middle of a payload.
        do_cfg(0, 1'b1);
        send_byte(8'hAB, 1'b1, 1'b0, 1'b0);
        send_byte(8'hCD, 1'b0, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0);
        check("mid_stream_vld", 32'(char_in_vld), 32'd1);
        check("mid_stream_en", 32'(enable), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        ld_q.delete(); ch_q.delete(); eop_q.delete();
        repeat (2) @(negedge clk);
        pay[0] = 8'h41; pay[1] = 8'h42;
        run_pkt(16'hABCD, 2, 2, 0, 1'b0, 1'b0, 0, 1'b0);
        check("post_reset_new", 32'(obs_new), 32'd1);
        check("post_reset_sid", 32'(obs_sid), 32'd0);

        // Fill the table and wrap the replacement pointer.
        do_reset();
        for (int i = 0; i < 66; i++) begin
            pay[0] = 8'(i);
            run_pkt(16'h1000 + 16'(i), 2, 1, 0, 1'b0, 1'b0, 0, 1'b0);
            if (i == 64) begin
                check("key65_sid", 32'(obs_sid), 32'd0);
                check("key65_new", 32'(obs_new), 32'd1);
            end
            if (i == 65) begin
                check("key66_sid", 32'(obs_sid), 32'd1);
                check("key66_new", 32'(obs_new), 32'd1);
            end
        end

        // Randomized traffic over a key pool larger than the table.
        for (int p = 0; p < 60; p++) begin
            logic [15:0] k;
            int hdr, plen, gap;
            bit stray, mid;
            k     = 16'h1000 + 16'($urandom_range(0, 99));
            hdr   = ($urandom_range(0, 15) == 0) ? 1 : 2;
            plen  = int'($urandom_range(0, 5));
            gap   = int'($urandom_range(0, 3));
            stray = ($urandom_range(0, 7) == 0);
            mid   = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) do_cfg(int'($urandom_range(0, 63)), 1'($urandom));
            run_pkt(k, hdr, plen, gap, stray, mid, int'($urandom_range(0, 63)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
